// File: rtl/accum_seq_tx.sv
// Transmit sequencer: serialises an arithmetic-series command into advance tokens
// and data beats for the accumulator receiver, tracking the receiver state in a shadow.
module accum_seq_tx #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8,
    parameter int GAP    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_base,
    input  logic [DATA_W-1:0] cmd_step,
    output logic              next,
    output logic [DATA_W-1:0] signal,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] expect_out
);

    typedef enum logic [2:0] {IDLE, SEEK_LOAD, LOAD, SEEK_ACC, ACCUM, FIN} state_t;

    localparam logic [3:0]        GAP_C = 4'(GAP);
    localparam logic [DATA_W-1:0] TOKEN = DATA_W'(1);

    state_t            state_q, state_d;
    logic [1:0]        sh_q, sh_d;
    logic [3:0]        gap_q, gap_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] step_q, step_d;
    logic [DATA_W-1:0] term_q, term_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              next_q, next_d;
    logic [DATA_W-1:0] signal_q, signal_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] expect_q, expect_d;
    logic [1:0]        sh_inc;

    assign sh_inc = (sh_q == 2'd2) ? 2'd0 : sh_q + 2'd1;

    // The state names the emission currently on the line; each edge decides the next one.
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        step_d   = step_q;
        term_d   = term_q;
        sum_d    = sum_q;
        next_d   = 1'b0;
        signal_d = '0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        expect_d = expect_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (cmd_valid) begin
                    busy_d = 1'b1;
                    base_d = cmd_base;
                    step_d = cmd_step;
                    cnt_d  = cmd_len - LEN_W'(1);
                    if (cmd_len == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else if (sh_q == 2'd2) begin
                        state_d  = LOAD;
                        next_d   = 1'b1;
                        signal_d = cmd_base;
                        term_d   = cmd_base;
                        sum_d    = cmd_base;
                        gap_d    = GAP_C;
                    end else begin
                        state_d  = SEEK_LOAD;
                        signal_d = TOKEN;
                        sh_d     = sh_inc;
                        gap_d    = GAP_C;
                    end
                end
            end
            SEEK_LOAD: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 4'd1;
                end else if (sh_q == 2'd2) begin
                    state_d  = LOAD;
                    next_d   = 1'b1;
                    signal_d = base_q;
                    term_d   = base_q;
                    sum_d    = base_q;
                    gap_d    = GAP_C;
                end else begin
                    signal_d = TOKEN;
                    sh_d     = sh_inc;
                    gap_d    = GAP_C;
                end
            end
            LOAD: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 4'd1;
                end else if (cnt_q == '0) begin
                    state_d  = FIN;
                    done_d   = 1'b1;
                    expect_d = sum_q;
                end else begin
                    state_d  = SEEK_ACC;
                    signal_d = TOKEN;
                    sh_d     = sh_inc;
                    gap_d    = GAP_C;
                end
            end
            SEEK_ACC, ACCUM: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 4'd1;
                end else if (state_q == ACCUM && cnt_q == '0) begin
                    state_d  = FIN;
                    done_d   = 1'b1;
                    expect_d = sum_q;
                end else if (state_q == SEEK_ACC && sh_q != 2'd1) begin
                    signal_d = TOKEN;
                    sh_d     = sh_inc;
                    gap_d    = GAP_C;
                end else begin
                    state_d  = ACCUM;
                    term_d   = term_q + step_q;
                    sum_d    = sum_q + term_d;
                    next_d   = 1'b1;
                    signal_d = term_d;
                    cnt_d    = cnt_q - LEN_W'(1);
                    gap_d    = GAP_C;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            gap_q    <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
            step_q   <= '0;
            term_q   <= '0;
            sum_q    <= '0;
            next_q   <= 1'b0;
            signal_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            expect_q <= '0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            step_q   <= step_d;
            term_q   <= term_d;
            sum_q    <= sum_d;
            next_q   <= next_d;
            signal_q <= signal_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            expect_q <= expect_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign next       = next_q;
    assign signal     = signal_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign expect_out = expect_q;

endmodule

// File: tb/tb_accum_seq_tx.sv
// Randomised bench for accum_seq_tx: a GAP=0 and a GAP=2 instance are checked
// cycle by cycle against a line-trace model built from the series rules.
module tb_accum_seq_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0 = 1'b0, v2 = 1'b0;
    logic [7:0]  len0 = '0, len2 = '0;
    logic [15:0] base0 = '0, base2 = '0, step0 = '0, step2 = '0;
    logic        rdy0, rdy2, nx0, nx2, bsy0, bsy2, dn0, dn2;
    logic [15:0] sig0, sig2, exp0, exp2;

    int checks = 0;
    int errors = 0;
    int sh_m[2];
    logic [15:0] exp_m[2];

    always #5 clk = ~clk;

    accum_seq_tx #(.DATA_W(16), .LEN_W(8), .GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_ready(rdy0),
        .cmd_len(len0), .cmd_base(base0), .cmd_step(step0),
        .next(nx0), .signal(sig0), .busy(bsy0), .done(dn0), .expect_out(exp0));

    accum_seq_tx #(.DATA_W(16), .LEN_W(8), .GAP(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v2), .cmd_ready(rdy2),
        .cmd_len(len2), .cmd_base(base2), .cmd_step(step2),
        .next(nx2), .signal(sig2), .busy(bsy2), .done(dn2), .expect_out(exp2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    // {ready, busy, done, next, signal, expect_out}
    function automatic logic [35:0] obs(input int sel);
        if (sel == 0) return {rdy0, bsy0, dn0, nx0, sig0, exp0};
        return {rdy2, bsy2, dn2, nx2, sig2, exp2};
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] l,
                         input logic [15:0] b, input logic [15:0] s);
        if (sel == 0) begin v0 = v; len0 = l; base0 = b; step0 = s; end
        else          begin v2 = v; len2 = l; base2 = b; step2 = s; end
    endtask

    task automatic scramble(input int sel);
        drive(sel, 1'b0, 8'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic run_cmd(input int sel, input int len, input logic [15:0] base,
                           input logic [15:0] step);
        int gap = (sel == 0) ? 0 : 2;
        logic [16:0] q[$];
        logic [15:0] term, sum;
        int waited = 0;
        while (obs(sel)[35] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", 64'(obs(sel)[35]), 64'(1));
        if (len > 0) begin
            for (int i = 0; i < (5 - sh_m[sel]) % 3; i++) begin
                q.push_back({1'b0, 16'd1});
                repeat (gap) q.push_back('0);
            end
            term = base;
            sum  = base;
            q.push_back({1'b1, base});
            repeat (gap) q.push_back('0);
            for (int k = 1; k < len; k++) begin
                if (k == 1) begin
                    repeat (2) begin
                        q.push_back({1'b0, 16'd1});
                        repeat (gap) q.push_back('0);
                    end
                end
                term = term + step;
                sum  = sum + term;
                q.push_back({1'b1, term});
                repeat (gap) q.push_back('0);
            end
        end
        drive(sel, 1'b1, 8'(len), base, step);
        @(negedge clk);
        scramble(sel);
        foreach (q[i]) begin
            check("line", 64'(obs(sel)), 64'({2'b01, 1'b0, q[i], exp_m[sel]}));
            @(negedge clk);
            scramble(sel);
        end
        if (len > 0) begin
            exp_m[sel] = sum;
            sh_m[sel]  = (len == 1) ? 2 : 1;
        end
        check("fin", 64'(obs(sel)), 64'({3'b011, 17'd0, exp_m[sel]}));
        @(negedge clk);
        check("after_fin", 64'(obs(sel)), 64'({3'b100, 17'd0, exp_m[sel]}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sh_m[0] = 0; sh_m[1] = 0;
        exp_m[0] = '0; exp_m[1] = '0;
        repeat (2) @(negedge clk);
        check("reset0", 64'(obs(0)), 64'({1'b1, 35'd0}));
        check("reset2", 64'(obs(1)), 64'({1'b1, 35'd0}));
        rst_n = 1'b1;
        @(negedge clk);

        // directed cases on the GAP=0 instance
        run_cmd(0, 3, 16'd5, 16'd2);
        run_cmd(0, 1, 16'h1234, 16'h0);
        run_cmd(0, 2, 16'h0100, 16'h0003);
        run_cmd(0, 0, 16'hBEEF, 16'h1111);
        run_cmd(0, 4, 16'hFFF0, 16'h0010);
        // gap pacing on the GAP=2 instance
        run_cmd(1, 3, 16'd5, 16'd2);
        run_cmd(1, 0, 16'h5555, 16'h1);

        for (int n = 0; n < 20; n++) begin
            int sel = n % 2;
            int len = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
            run_cmd(sel, len, 16'($urandom), 16'($urandom));
        end

        // abort during ACCUM of a long command on the GAP=0 instance
        begin
            int seek = (5 - sh_m[0]) % 3;
            drive(0, 1'b1, 8'd5, 16'h0A00, 16'h0001);
            @(negedge clk);
            scramble(0);
            repeat (seek + 3) @(negedge clk);
            check("in_accum", 64'({nx0, bsy0}), 64'(2'b11));
            #1 rst_n = 1'b0;
            #1;
            check("async_rst0", 64'(obs(0)), 64'({1'b1, 35'd0}));
            check("async_rst2", 64'(obs(1)), 64'({1'b1, 35'd0}));
            @(negedge clk);
            rst_n = 1'b1;
            sh_m[0] = 0; sh_m[1] = 0;
            exp_m[0] = '0; exp_m[1] = '0;
            @(negedge clk);
        end
        run_cmd(0, 1, 16'h00AB, 16'h0);
        run_cmd(1, 1, 16'h00CD, 16'h0);
        run_cmd(0, 3, 16'h7FFF, 16'h8001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
